// File: rtl/quantdeser_if.sv
// quantdeser_if: control, serial-in and parallel-out bundle of the deserializer
// master: drives start, bdin (precision-1), msbidx, signext, din (serial, MSB first)
// slave:  drives dout (aligned word), dvalid (one-cycle result strobe), busy (capturing)
interface quantdeser_if #(
  parameter int BDOUT = 32,
  parameter int BDINMAX = 32
);
  localparam int MAXBDOP = $clog2(BDOUT);
  localparam int MAXBDIP = $clog2(BDINMAX);
  logic start;
  logic [MAXBDIP-1:0] bdin;
  logic [MAXBDOP-1:0] msbidx;
  logic signext;
  logic din;
  logic [BDOUT-1:0] dout;
  logic dvalid;
  logic busy;
  modport master(output start, bdin, msbidx, signext, din, input dout, dvalid, busy);
  modport slave(input start, bdin, msbidx, signext, din, output dout, dvalid, busy);
endinterface

// File: rtl/quantdeser.sv
// quantdeser: captures a P-bit MSB-first serial value and aligns its MSB to dout[msbidx]
// clk: rising-edge clock; clr: synchronous active-high reset
// bus: quantdeser_if slave (start/bdin/msbidx/signext/din in, dout/dvalid/busy out)
module quantdeser #(
  parameter int BDOUT = 32,
  parameter int BDINMAX = 32
) (
  input logic clk,
  input logic clr,
  quantdeser_if.slave bus
);
  localparam int MAXBDOP = $clog2(BDOUT);
  localparam int MAXBDIP = $clog2(BDINMAX);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [BDINMAX-1:0] acc;
  logic [MAXBDIP-1:0] cnt, bd, bd_in;
  logic [MAXBDOP-1:0] ms;
  logic sx;
  logic [BDOUT-1:0] val, shifted, fill, aligned;
  // val includes the bit arriving on this edge, so the result is ready on the last sample edge
  always_comb begin
    bd_in = (int'(bus.bdin) >= BDINMAX - 1) ? MAXBDIP'(BDINMAX - 1) : bus.bdin;
    val = BDOUT'({acc[BDINMAX-2:0], bus.din});
    shifted = (ms >= MAXBDOP'(bd)) ? val << (ms - MAXBDOP'(bd)) : val >> (MAXBDOP'(bd) - ms);
    // mask of bits above msbidx; wraps to zero when msbidx is the top bit
    fill = (sx && val[bd]) ? ~((BDOUT'(2) << ms) - BDOUT'(1)) : '0;
    aligned = shifted | fill;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      bd <= '0;
      ms <= '0;
      sx <= 1'b0;
      bus.dout <= '0;
      bus.dvalid <= 1'b0;
      bus.busy <= 1'b0;
    end else if (bus.start) begin
      state <= SHIFT;
      acc <= '0;
      cnt <= '0;
      bd <= bd_in;
      ms <= bus.msbidx;
      sx <= bus.signext;
      bus.dvalid <= 1'b0;
      bus.busy <= 1'b1;
    end else if (state == SHIFT) begin
      acc <= {acc[BDINMAX-2:0], bus.din};
      cnt <= cnt + MAXBDIP'(1);
      if (cnt == bd) begin
        state <= DONE;
        bus.dout <= aligned;
        bus.dvalid <= 1'b1;
        bus.busy <= 1'b0;
      end
    end else begin
      state <= IDLE;
      bus.dvalid <= 1'b0;
      bus.busy <= 1'b0;
    end
  end
endmodule

// File: doc/quantdeser.md
QUANTDESER -- requirements
Module: quantdeser

Interface
REQ-001 Parameter BDOUT, default 32: parallel output word width in bits.
REQ-002 Parameter BDINMAX, default 32: maximum serial precision in bits; BDINMAX <= BDOUT.
REQ-003 Derived MAXBDOP = $clog2(BDOUT) and MAXBDIP = $clog2(BDINMAX): field widths only, not overridable.
REQ-004 clk  input  1  single clock; all logic rising-edge triggered.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a capture; control inputs are sampled on the same edge.
REQ-007 bdin  input  MAXBDIP  serial precision minus one; precision P = bdin+1.
REQ-008 msbidx  input  MAXBDOP  output bit position receiving the first (MSB) serial bit.
REQ-009 signext  input  1  1 = fill bits above msbidx with the received MSB; 0 = fill with zero.
REQ-010 din  input  1  serial data, MSB first.
REQ-011 dout  output  BDOUT  reassembled, aligned word.
REQ-012 dvalid  output  1  one-cycle pulse; dout is updated and valid.
REQ-013 busy  output  1  high while bits are being captured.

Function
REQ-014 The state machine SHALL have states IDLE, SHIFT and DONE.
REQ-015 IDLE: start=1 latches bdin, msbidx and signext, clears the shift accumulator and bit counter, and goes to SHIFT.
REQ-016 SHIFT: din is sampled on each rising edge into the accumulator LSB with a left shift; capture is MSB first.
REQ-017 SHIFT: the first bit is sampled on the edge after the start edge; exactly P bits are sampled on P consecutive edges.
REQ-018 The bit counter counts 0..bdin; when the bit at count == bdin is sampled, the state goes to DONE.
REQ-019 DONE: dvalid=1 for exactly one cycle; dout holds the aligned result from that cycle onward.
REQ-020 From DONE: start=1 behaves as in IDLE (back-to-back capture with no gap cycle); otherwise go to IDLE.
REQ-021 busy SHALL be 1 exactly in SHIFT; dvalid SHALL be 1 exactly in DONE.
REQ-022 Latency: dvalid asserts P+1 cycles after the start edge.
REQ-023 Alignment, msbidx >= bdin: the captured P-bit value is shifted left by (msbidx - bdin), so its MSB lands at dout[msbidx] and the lower bits are zero.
REQ-024 Alignment, msbidx < bdin: the value is shifted right by (bdin - msbidx), dropping the LSBs; the MSB still lands at dout[msbidx].
REQ-025 Bits of dout above msbidx SHALL equal the received MSB when signext=1, and 0 otherwise.
REQ-026 msbidx = BDOUT-1: there are no fill bits and signext has no effect.
REQ-027 bdin >= BDINMAX (out of range): the effective precision SHALL saturate to BDINMAX.
REQ-028 start=1 during SHIFT aborts the current capture with no dvalid, relatches the control inputs, clears the counter, and restarts SHIFT.
REQ-029 dout SHALL change only on the DONE transition, and otherwise SHALL hold its last value.
REQ-030 Control inputs and din SHALL be ignored outside the edges specified above.
REQ-031 The bit order and timing SHALL be the exact inverse of the team's quantizing serializer: that block's start and dout connect directly to this block's start and din with no retiming.

Reset
REQ-032 clr=1 on a rising edge SHALL force state IDLE, dout=0, dvalid=0, busy=0 and clear the accumulator, counter and latched controls.
REQ-033 clr SHALL take priority over start and over any in-progress capture; a capture interrupted by clr produces no dvalid.
REQ-034 On the first edge after clr deasserts, start is honoured normally.

Verification
REQ-035 bdin=0, msbidx=0, signext=0, din=1 on the edge after start -> dvalid 2 cycles after start, dout=0x00000001.
REQ-036 bdin=1, msbidx=31, signext=0, bits 1,0 -> dout=0x80000000; repeat with bits 1,1 and signext=1 -> dout=0xC0000000.
REQ-037 bdin=3, msbidx=7, signext=1, bits 1,0,1,1 -> dout=0xFFFFFFB0; repeat with signext=0 -> dout=0x000000B0.
REQ-038 bdin=31, msbidx=31, 32 bits of 0x00000005 MSB first -> dvalid 33 cycles after start, dout=0x00000005.
REQ-039 Loopback with the serializer: random din, bdin and msbidx >= bdin -> dout equals the serializer's selected field realigned to msbidx, checked over 1000 vectors including back-to-back starts.
REQ-040 Mid-capture events: start again 2 cycles into an 8-bit capture -> no dvalid for the first capture and a correct second result; clr mid-capture -> dout=0, no dvalid.
